// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: buffers TX words in a small FIFO, sequences one frame per word
// towards the SPI IO stage, and captures the returned RX word after the IO pipeline delay.
module spi_frame_ctrl #(
    parameter int unsigned CLKDIV     = 4,
    parameter int unsigned BITWIDTH   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CAP_DLY    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BITWIDTH-1:0] s_data,
    input  logic                abort,
    output logic [BITWIDTH-1:0] tx_word,
    output logic                sync_out,
    input  logic [BITWIDTH-1:0] rx_word,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BITWIDTH-1:0] m_data,
    output logic                busy,
    output logic                frame_done,
    output logic                rx_overrun
);

    localparam int unsigned FRAME_CYC = BITWIDTH * CLKDIV / 2;
    localparam int unsigned CNT_MAX   = (FRAME_CYC > CAP_DLY) ? FRAME_CYC : CAP_DLY;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W     = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TAIL   = 2'd3
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BITWIDTH-1:0] tx_word_q;
    logic                sync_out_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                m_valid_q;
    logic [BITWIDTH-1:0] m_data_q;
    logic                rx_overrun_q;

    logic [BITWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [OCC_W-1:0]    occ_q;

    logic fifo_full_c;
    logic fifo_empty_c;
    logic push_c;
    logic pop_c;
    logic last_active_c;
    logic last_tail_c;
    logic capture_c;

    assign fifo_full_c  = (occ_q == OCC_W'(FIFO_DEPTH));
    assign fifo_empty_c = (occ_q == '0);
    assign push_c       = s_valid && !fifo_full_c && !abort;
    assign pop_c        = (state_q == ST_LOAD);

    assign last_active_c = (state_q == ST_ACTIVE) && (cnt_q == CNT_W'(FRAME_CYC - 1));
    assign last_tail_c   = (state_q == ST_TAIL) && (cnt_q == CNT_W'(CAP_DLY - 1));
    // With no IO pipeline delay the RX word is taken on the final ACTIVE cycle.
    assign capture_c     = !abort && ((CAP_DLY == 0) ? last_active_c : last_tail_c);

    // FIFO storage carries no reset; validity is tracked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (pop_c && !push_c) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    // Frame sequencer with registered sync/busy/tx_word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_word_q  <= '0;
            sync_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (abort) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sync_out_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_c) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    tx_word_q  <= mem_q[rd_ptr_q];
                    state_q    <= ST_ACTIVE;
                    cnt_q      <= '0;
                    sync_out_q <= 1'b1;
                end
                ST_ACTIVE: begin
                    if (last_active_c) begin
                        sync_out_q <= 1'b0;
                        cnt_q      <= '0;
                        if (CAP_DLY == 0) begin
                            state_q <= fifo_empty_c ? ST_IDLE : ST_LOAD;
                            busy_q  <= !fifo_empty_c;
                        end else begin
                            state_q <= ST_TAIL;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_TAIL: begin
                    if (last_tail_c) begin
                        cnt_q   <= '0;
                        state_q <= fifo_empty_c ? ST_IDLE : ST_LOAD;
                        busy_q  <= !fifo_empty_c;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= '0;
                    sync_out_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // RX capture side; a capture always beats a same-cycle consumer handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            frame_done_q <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            frame_done_q <= capture_c;
            if (capture_c) begin
                m_data_q  <= rx_word;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (abort) begin
                rx_overrun_q <= 1'b0;
            end else if (capture_c && m_valid_q && !m_ready) begin
                rx_overrun_q <= 1'b1;
            end
        end
    end

    assign s_ready    = !fifo_full_c;
    assign tx_word    = tx_word_q;
    assign sync_out   = sync_out_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: a default build plus a CAP_DLY=0 build,
// with a negedge monitor collecting frame events that each test compares to its scoreboard.
module tb_spi_frame_ctrl;

    localparam int unsigned BW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_valid, s_ready, abort, sync_out, m_valid, m_ready, busy, frame_done, rx_overrun;
    logic [BW-1:0] s_data, tx_word, rx_word, m_data;
    logic          rx_loop;
    logic [BW-1:0] rx_fixed;

    logic          s_valid0, s_ready0, abort0, sync_out0, m_valid0, m_ready0, busy0, frame_done0, rx_overrun0;
    logic [BW-1:0] s_data0, tx_word0, rx_word0, m_data0;

    // IO-stage stand-in: either a fixed RX word or the inverted TX word.
    assign rx_word  = rx_loop ? ~tx_word : rx_fixed;
    assign rx_word0 = ~tx_word0;

    spi_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .abort(abort), .tx_word(tx_word), .sync_out(sync_out), .rx_word(rx_word),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
        .frame_done(frame_done), .rx_overrun(rx_overrun)
    );

    spi_frame_ctrl #(.CAP_DLY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
        .abort(abort0), .tx_word(tx_word0), .sync_out(sync_out0), .rx_word(rx_word0),
        .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0), .busy(busy0),
        .frame_done(frame_done0), .rx_overrun(rx_overrun0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] exp_tx[$];
    logic [BW-1:0] exp_rx[$];

    int            cyc = 0;
    logic          sync_prev = 1'b0;
    logic          sync0_prev = 1'b0;
    int            hi_cnt = 0;
    int            hi0_cnt = 0;
    int            obs_rise[$], obs_fall[$], obs_len[$], obs_done[$];
    logic [BW-1:0] obs_tx[$], obs_rx[$];
    logic          obs_mv[$], obs_ovr[$];
    int            obs0_rise[$], obs0_fall[$], obs0_len[$], obs0_done[$];
    logic [BW-1:0] obs0_rx[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            sync_prev  = 1'b0;
            sync0_prev = 1'b0;
            hi_cnt     = 0;
            hi0_cnt    = 0;
        end else begin
            if (sync_out && !sync_prev) begin
                obs_rise.push_back(cyc);
                obs_tx.push_back(tx_word);
                hi_cnt = 0;
            end
            if (sync_out) hi_cnt = hi_cnt + 1;
            if (!sync_out && sync_prev) begin
                obs_fall.push_back(cyc);
                obs_len.push_back(hi_cnt);
            end
            if (frame_done) begin
                obs_done.push_back(cyc);
                obs_rx.push_back(m_data);
                obs_mv.push_back(m_valid);
                obs_ovr.push_back(rx_overrun);
            end
            sync_prev = sync_out;
            if (sync_out0 && !sync0_prev) begin
                obs0_rise.push_back(cyc);
                hi0_cnt = 0;
            end
            if (sync_out0) hi0_cnt = hi0_cnt + 1;
            if (!sync_out0 && sync0_prev) begin
                obs0_fall.push_back(cyc);
                obs0_len.push_back(hi0_cnt);
            end
            if (frame_done0) begin
                obs0_done.push_back(cyc);
                obs0_rx.push_back(m_data0);
            end
            sync0_prev = sync_out0;
        end
    end

    task automatic clear_obs();
        obs_rise.delete(); obs_fall.delete(); obs_len.delete(); obs_done.delete();
        obs_tx.delete(); obs_rx.delete(); obs_mv.delete(); obs_ovr.delete();
        obs0_rise.delete(); obs0_fall.delete(); obs0_len.delete(); obs0_done.delete();
        obs0_rx.delete();
        exp_tx.delete(); exp_rx.delete();
    endtask

    // Offer one word at the next negedge; acc reports whether the coming posedge takes it.
    task automatic drive_push(input logic [BW-1:0] d, output bit acc);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        acc     = s_ready && !abort;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({s_ready, sync_out, m_valid, busy, frame_done, rx_overrun} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 100000",
                     {s_ready, sync_out, m_valid, busy, frame_done, rx_overrun});
        end
        n_tests++;
        if (tx_word !== 8'h00) begin
            n_fail++; $display("FAIL reset_tx_word: got %h, required 00", tx_word);
        end
        n_tests++;
        if (m_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_m_data: got %h, required 00", m_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit acc;
        logic [BW-1:0] got;
        int d;
        clear_obs();
        rx_loop = 1'b0; rx_fixed = 8'h3C; m_ready = 1'b0;
        drive_push(8'hA5, acc);
        if (acc) begin exp_tx.push_back(8'hA5); exp_rx.push_back(8'h3C); end
        n_tests++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b, required 1", acc); end
        @(negedge clk); s_valid = 1'b0;
        for (int k = 0; k < 60 && obs_done.size() < 1; k++) @(negedge clk);
        n_tests++;
        if (obs_done.size() != 1) begin
            n_fail++; $display("FAIL single_frames: got %0d, required 1", obs_done.size());
        end
        got = (obs_tx.size() > 0) ? obs_tx[0] : 'x;
        n_tests++;
        if (exp_tx.size() == 0 || got !== exp_tx.pop_front()) begin
            n_fail++; $display("FAIL single_tx_word: got %h, required a5", got);
        end
        n_tests++;
        if (obs_len.size() == 0 || obs_len[0] != 16) begin
            n_fail++; $display("FAIL single_sync_len: got %0d, required 16",
                               (obs_len.size() > 0) ? obs_len[0] : -1);
        end
        d = (obs_fall.size() > 0 && obs_done.size() > 0) ? obs_done[0] - obs_fall[0] : -1;
        n_tests++;
        if (d != 3) begin n_fail++; $display("FAIL single_cap_delay: got %0d, required 3", d); end
        got = (obs_rx.size() > 0) ? obs_rx[0] : 'x;
        n_tests++;
        if (exp_rx.size() == 0 || got !== exp_rx.pop_front()) begin
            n_fail++; $display("FAIL single_m_data: got %h, required 3c", got);
        end
        n_tests++;
        if (obs_mv.size() == 0 || obs_mv[0] !== 1'b1) begin
            n_fail++; $display("FAIL single_m_valid: m_valid not 1 at frame_done");
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, m_valid} !== 2'b01 || tx_word !== 8'hA5) begin
            n_fail++; $display("FAIL single_idle_hold: busy/m_valid %b tx %h, required 01 a5",
                               {busy, m_valid}, tx_word);
        end
        m_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_consume: m_valid %b, required 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [BW-1:0] w;
        logic [BW-1:0] got;
        int guard;
        clear_obs();
        m_ready = 1'b1; rx_loop = 1'b1;
        w = 8'h01; guard = 0;
        while (w <= 8'h05 && guard < 50) begin
            drive_push(w, acc);
            if (acc) begin exp_tx.push_back(w); exp_rx.push_back(~w); w = w + 8'h01; end
            guard++;
        end
        drive_push(8'h66, acc);
        n_tests++;
        if (acc !== 1'b0) begin n_fail++; $display("FAIL b2b_full: s_ready %b with 4 stored, required 0", acc); end
        @(negedge clk); s_valid = 1'b0;
        for (int k = 0; k < 200 && obs_done.size() < 5; k++) @(negedge clk);
        repeat (30) @(negedge clk);
        n_tests++;
        if (obs_done.size() != 5) begin
            n_fail++; $display("FAIL b2b_frames: got %0d, required 5", obs_done.size());
        end
        for (int i = 0; i < 5; i++) begin
            got = (obs_tx.size() > i) ? obs_tx[i] : 'x;
            n_tests++;
            if (exp_tx.size() == 0 || got !== exp_tx.pop_front()) begin
                n_fail++; $display("FAIL b2b_tx_%0d: got %h, required %h", i, got, 8'(i + 1));
            end
            got = (obs_rx.size() > i) ? obs_rx[i] : 'x;
            n_tests++;
            if (exp_rx.size() == 0 || got !== exp_rx.pop_front()) begin
                n_fail++; $display("FAIL b2b_rx_%0d: got %h, required %h", i, got, ~8'(i + 1));
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs_rise.size() <= i + 1 || obs_rise[i + 1] - obs_rise[i] != 20) begin
                n_fail++; $display("FAIL b2b_period_%0d: got %0d, required 20", i,
                                   (obs_rise.size() > i + 1) ? obs_rise[i + 1] - obs_rise[i] : -1);
            end
        end
    endtask

    task automatic test_overrun();
        bit acc;
        logic [BW-1:0] got;
        clear_obs();
        m_ready = 1'b0; rx_loop = 1'b1;
        drive_push(8'h10, acc);
        if (acc) exp_rx.push_back(~8'h10);
        drive_push(8'h20, acc);
        if (acc) exp_rx.push_back(~8'h20);
        @(negedge clk); s_valid = 1'b0;
        for (int k = 0; k < 100 && obs_done.size() < 2; k++) @(negedge clk);
        n_tests++;
        if (obs_ovr.size() != 2 || obs_ovr[0] !== 1'b0 || obs_ovr[1] !== 1'b1) begin
            n_fail++; $display("FAIL ovr_flag: %0d captures, flags not 0 then 1", obs_ovr.size());
        end
        void'(exp_rx.pop_front());
        got = (obs_rx.size() > 1) ? obs_rx[1] : 'x;
        n_tests++;
        if (exp_rx.size() == 0 || got !== exp_rx.pop_front()) begin
            n_fail++; $display("FAIL ovr_m_data: got %h, required df", got);
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (rx_overrun !== 1'b1 || m_data !== 8'hDF) begin
            n_fail++; $display("FAIL ovr_sticky: rx_overrun %b m_data %h, required 1 df", rx_overrun, m_data);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_tests++;
        if ({rx_overrun, m_valid} !== 2'b01 || m_data !== 8'hDF) begin
            n_fail++; $display("FAIL ovr_abort_clear: ovr/m_valid %b m_data %h, required 01 df",
                               {rx_overrun, m_valid}, m_data);
        end
        m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit acc;
        logic [BW-1:0] got;
        int k;
        clear_obs();
        m_ready = 1'b1; rx_loop = 1'b1;
        drive_push(8'h31, acc); if (acc) exp_tx.push_back(8'h31);
        drive_push(8'h32, acc); if (acc) exp_tx.push_back(8'h32);
        drive_push(8'h33, acc); if (acc) exp_tx.push_back(8'h33);
        @(negedge clk); s_valid = 1'b0;
        k = 0;
        while (!sync_out && k < 50) begin @(negedge clk); k++; end
        repeat (7) @(negedge clk);
        abort = 1'b1; s_valid = 1'b1; s_data = 8'h77;
        @(negedge clk); abort = 1'b0; s_valid = 1'b0;
        n_tests++;
        if ({busy, sync_out, s_ready, frame_done} !== 4'b0010) begin
            n_fail++; $display("FAIL abort_next: busy/sync/s_ready/done %b, required 0010",
                               {busy, sync_out, s_ready, frame_done});
        end
        repeat (40) @(negedge clk);
        n_tests++;
        if (obs_done.size() != 0 || obs_rise.size() != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet: %0d captures %0d frames busy %b, required 0 1 0",
                               obs_done.size(), obs_rise.size(), busy);
        end
        got = (obs_tx.size() > 0) ? obs_tx[0] : 'x;
        n_tests++;
        if (exp_tx.size() == 0 || got !== exp_tx.pop_front()) begin
            n_fail++; $display("FAIL abort_tx: got %h, required 31", got);
        end
        exp_tx.delete();
    endtask

    task automatic test_reset_mid();
        bit acc;
        logic [BW-1:0] got;
        int k;
        clear_obs();
        m_ready = 1'b1; rx_loop = 1'b1;
        drive_push(8'h42, acc);
        drive_push(8'h43, acc);
        @(negedge clk); s_valid = 1'b0;
        k = 0;
        while (!sync_out && k < 50) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({s_ready, sync_out, m_valid, busy, frame_done, rx_overrun} !== 6'b100000 ||
            tx_word !== 8'h00 || m_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_outputs: flags %b tx %h m_data %h, required 100000 00 00",
                               {s_ready, sync_out, m_valid, busy, frame_done, rx_overrun}, tx_word, m_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        repeat (40) @(negedge clk);
        n_tests++;
        if (obs_rise.size() != 0 || obs_done.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_quiet: %0d frames %0d captures busy %b, required 0 0 0",
                               obs_rise.size(), obs_done.size(), busy);
        end
        drive_push(8'h99, acc);
        if (acc) exp_tx.push_back(8'h99);
        @(negedge clk); s_valid = 1'b0;
        for (int j = 0; j < 60 && obs_done.size() < 1; j++) @(negedge clk);
        got = (obs_tx.size() > 0) ? obs_tx[0] : 'x;
        n_tests++;
        if (exp_tx.size() == 0 || got !== exp_tx.pop_front()) begin
            n_fail++; $display("FAIL rstmid_new_frame: got %h, required 99", got);
        end
    endtask

    task automatic test_capdly0();
        bit acc;
        int d;
        clear_obs();
        m_ready0 = 1'b1;
        @(negedge clk); s_valid0 = 1'b1; s_data0 = 8'h5A; acc = s_ready0;
        if (acc) exp_rx.push_back(~8'h5A);
        @(negedge clk); s_data0 = 8'h3B; acc = s_ready0;
        if (acc) exp_rx.push_back(~8'h3B);
        @(negedge clk); s_valid0 = 1'b0;
        for (int k = 0; k < 80 && obs0_done.size() < 2; k++) @(negedge clk);
        d = (obs0_rise.size() > 1) ? obs0_rise[1] - obs0_rise[0] : -1;
        n_tests++;
        if (d != 17) begin n_fail++; $display("FAIL cap0_period: got %0d, required 17", d); end
        n_tests++;
        if (obs0_len.size() == 0 || obs0_len[0] != 16) begin
            n_fail++; $display("FAIL cap0_sync_len: got %0d, required 16",
                               (obs0_len.size() > 0) ? obs0_len[0] : -1);
        end
        d = (obs0_fall.size() > 0 && obs0_done.size() > 0) ? obs0_done[0] - obs0_fall[0] : -1;
        n_tests++;
        if (d != 0) begin n_fail++; $display("FAIL cap0_cap_delay: got %0d, required 0", d); end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (obs0_rx.size() <= i || exp_rx.size() == 0 || obs0_rx[i] !== exp_rx.pop_front()) begin
                n_fail++; $display("FAIL cap0_m_data_%0d: got %h", i,
                                   (obs0_rx.size() > i) ? obs0_rx[i] : 8'hxx);
            end
        end
    endtask

    initial begin
        s_valid = 1'b0; s_data = '0; abort = 1'b0; m_ready = 1'b0;
        rx_loop = 1'b0; rx_fixed = '0;
        s_valid0 = 1'b0; s_data0 = '0; abort0 = 1'b0; m_ready0 = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_capdly0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 SHALL have parameter CLKDIV, default 4, SPI clock divide ratio of the downstream SPI IO stage (even, >=2).
REQ-002 SHALL have parameter BITWIDTH, default 8, bits per SPI frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, TX word FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter CAP_DLY, default 3, clk cycles between frame end and RX capture (covers IO-stage pipeline), range 0..15.
REQ-005 SHALL have local constant FRAME_CYC = BITWIDTH*CLKDIV/2 clk cycles per frame (16 at defaults).
REQ-006 clk  input  1  system clock; all logic rising-edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 s_valid  input  1  TX word offered.
REQ-009 s_ready  output  1  FIFO not full; push when s_valid&&s_ready.
REQ-010 s_data  input  BITWIDTH  TX word.
REQ-011 abort  input  1  synchronous flush/return-to-idle strobe.
REQ-012 tx_word  output  BITWIDTH  word to IO stage tx_din, held for the whole frame.
REQ-013 sync_out  output  1  frame-active to IO stage sync_in.
REQ-014 rx_word  input  BITWIDTH  IO stage rx_dout.
REQ-015 m_valid  output  1  captured RX word available.
REQ-016 m_ready  input  1  consumer accepts; transfer on m_valid&&m_ready.
REQ-017 m_data  output  BITWIDTH  captured RX word.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 frame_done  output  1  one-cycle pulse on each RX capture.
REQ-020 rx_overrun  output  1  sticky: capture occurred while m_valid=1.

Function
REQ-021 FIFO SHALL be first-word-first-out; push when s_valid&&s_ready; s_ready = !full, combinational from the registered occupancy count.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; s_data while full SHALL be ignored.
REQ-023 FSM states SHALL be IDLE, LOAD, ACTIVE, TAIL.
REQ-024 IDLE -> LOAD when FIFO non-empty; LOAD lasts 1 cycle, pops FIFO head into tx_word.
REQ-025 ACTIVE SHALL last exactly FRAME_CYC cycles; sync_out = 1 throughout ACTIVE, 0 in every other state, registered.
REQ-026 After ACTIVE: TAIL for CAP_DLY cycles, sync_out=0, tx_word held; if CAP_DLY=0, TAIL skipped.
REQ-027 Capture on last TAIL cycle (last ACTIVE cycle if CAP_DLY=0): m_data<=rx_word, m_valid<=1, frame_done=1 next cycle.
REQ-028 After capture: -> LOAD if FIFO non-empty, else IDLE; back-to-back period = 1+FRAME_CYC+CAP_DLY cycles (20 at defaults).
REQ-029 tx_word SHALL change only in LOAD; it retains its value in IDLE.
REQ-030 m_valid cleared on m_valid&&m_ready unless a capture occurs the same cycle (capture wins, m_valid stays 1).
REQ-031 Capture with m_valid=1 and no m_ready SHALL overwrite m_data and set rx_overrun.
REQ-032 Frame counter SHALL be wide enough for max(FRAME_CYC,CAP_DLY) and never wrap within a state.
REQ-033 abort SHALL in the next cycle: state IDLE, FIFO empty, sync_out 0, rx_overrun 0; m_valid/m_data unchanged; a push coincident with abort SHALL be dropped.
REQ-034 abort on the capture cycle SHALL suppress that capture and frame_done.

Reset
REQ-035 On rst_n low, asynchronously: state IDLE, FIFO empty (s_ready=1), tx_word=0, sync_out=0, m_valid=0, m_data=0, busy=0, frame_done=0, rx_overrun=0.
REQ-036 Reset mid-frame SHALL discard the frame and all FIFO contents; no capture after release.

Verification
REQ-037 Push 0xA5 from idle, rx_word=0x3C -> tx_word=0xA5 from cycle after LOAD, sync_out high exactly 16 cycles, m_data=0x3C with m_valid 1 and frame_done pulse 3 cycles after sync_out falls.
REQ-038 Push 0x01..0x05 back-to-back, m_ready=1 -> s_ready low after 4 words stored, 5 frames, sync_out rising edges 20 cycles apart, tx_word order 0x01..0x05.
REQ-039 Two frames with m_ready=0 -> second capture overwrites m_data, rx_overrun=1 stays set until abort.
REQ-040 abort at ACTIVE cycle 8 with 2 words queued -> next cycle IDLE, sync_out=0, s_ready=1, no frame_done.
REQ-041 rst_n low at ACTIVE cycle 5 -> all outputs at REQ-035 values immediately; no activity after release until a new push.
REQ-042 CAP_DLY=0 build, push 0x5A -> capture on last ACTIVE cycle, frame period 17 cycles.
